// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM access arbiter.
// States, requester ids and the VGA timing code for active video.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    ACK
  } arb_state_t;

  typedef enum logic {
    REQ_VGA,
    REQ_CPU
  } req_id_t;

  localparam logic [1:0] VGA_ACTIVE = 2'd2;

endpackage

// File: rtl/sram_arb_select.sv
// Combinational winner picker for the SRAM arbiter.
// Starved CPU, then active-video VGA, then round-robin, then lone requester.
module sram_arb_select
  import sram_arb_pkg::*;
(
  input  logic       vga_req,
  input  logic       cpu_req,
  input  logic [1:0] vga_state,
  input  logic       starve,
  input  req_id_t    last_grant,
  output req_id_t    winner,
  output logic       valid
);

  logic cpu_force;
  logic vga_pref;
  logic both;
  logic only_cpu;

  // Arms are made mutually exclusive so the decoder can be unique
  assign cpu_force = starve & cpu_req;
  assign vga_pref  = ~cpu_force & vga_req &
                     (vga_state == VGA_ACTIVE);
  assign both      = ~cpu_force & ~vga_pref &
                     vga_req & cpu_req;
  assign only_cpu  = ~cpu_force & ~vga_pref &
                     ~both & cpu_req;

  always_comb begin
    winner = REQ_VGA;
    valid  = vga_req | cpu_req;
    unique case (1'b1)
      cpu_force: winner = REQ_CPU;
      vga_pref:  winner = REQ_VGA;
      both: winner = (last_grant == REQ_CPU) ?
                     REQ_VGA : REQ_CPU;
      only_cpu:  winner = REQ_CPU;
      default:   winner = REQ_VGA;
    endcase
  end

endmodule

// File: rtl/sram_access_arbiter.sv
// Shares one SRAM port between VGA pixel fetch and the CPU LSU.
// Define ARB_PERF_CNT_EN to add grant and busy-stall counters.
module sram_access_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W           = 32,
  parameter int DATA_W           = 32,
  parameter int CPU_STARVE_LIMIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        VGA_state,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              vga_ack,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [3:0]        cpu_byte_sel,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              sram_busy,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              sram_read,
  output logic              sram_write,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic [3:0]        sram_byte_sel
`ifdef ARB_PERF_CNT_EN
  ,output logic [15:0]      vga_grant_cnt
  ,output logic [15:0]      cpu_grant_cnt
  ,output logic [15:0]      busy_stall_cnt
`endif
);

  localparam int SW = $clog2(CPU_STARVE_LIMIT + 1);

  arb_state_t    state, state_n;
  req_id_t       grant, last_grant, sel_id;
  logic          sel_valid;
  logic          we_q;
  logic [SW-1:0] starve_cnt;
  logic          starve;
  logic          cpu_active;

  assign starve = starve_cnt >= SW'(CPU_STARVE_LIMIT);

  sram_arb_select u_sel (
    .vga_req    (vga_req),
    .cpu_req    (cpu_req),
    .vga_state  (VGA_state),
    .starve     (starve),
    .last_grant (last_grant),
    .winner     (sel_id),
    .valid      (sel_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n    = state;
    sram_read  = 1'b0;
    sram_write = 1'b0;
    vga_ack    = 1'b0;
    cpu_ack    = 1'b0;
    unique case (state)
      IDLE: if (sel_valid) state_n = ISSUE;
      ISSUE: begin
        sram_read  = ~we_q;
        sram_write = we_q;
        state_n    = WAIT;
      end
      WAIT: if (!sram_busy) state_n = ACK;
      ACK: begin
        vga_ack = (grant == REQ_VGA);
        cpu_ack = (grant == REQ_CPU);
        state_n = IDLE;
      end
    endcase
  end

  // The IDLE cycle that picks the CPU already counts as its grant
  assign cpu_active = (state == IDLE) ?
                      (sel_valid && sel_id == REQ_CPU) :
                      (grant == REQ_CPU);

  always_ff @(posedge clk) begin
    if (rst) begin
      grant         <= REQ_VGA;
      last_grant    <= REQ_CPU;
      we_q          <= 1'b0;
      sram_addr     <= '0;
      sram_wdata    <= '0;
      sram_byte_sel <= 4'b0000;
      vga_rdata     <= '0;
      cpu_rdata     <= '0;
      starve_cnt    <= '0;
    end else begin
      if (state == IDLE && sel_valid) begin
        grant <= sel_id;
        if (sel_id == REQ_CPU) begin
          we_q          <= cpu_we;
          sram_addr     <= cpu_addr;
          sram_wdata    <= cpu_wdata;
          sram_byte_sel <= cpu_byte_sel;
        end else begin
          we_q          <= 1'b0;
          sram_addr     <= vga_addr;
          sram_wdata    <= '0;
          sram_byte_sel <= 4'b1111;
        end
      end
      if (state == WAIT && !sram_busy && !we_q) begin
        if (grant == REQ_VGA) vga_rdata <= sram_rdata;
        else                  cpu_rdata <= sram_rdata;
      end
      if (state == ACK) last_grant <= grant;
      if (cpu_ack)
        starve_cnt <= '0;
      else if (cpu_req && !cpu_active && !starve)
        starve_cnt <= starve_cnt + SW'(1);
    end
  end

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_grant_cnt  <= '0;
      cpu_grant_cnt  <= '0;
      busy_stall_cnt <= '0;
    end else begin
      if (vga_ack && vga_grant_cnt != 16'hFFFF)
        vga_grant_cnt <= vga_grant_cnt + 16'd1;
      if (cpu_ack && cpu_grant_cnt != 16'hFFFF)
        cpu_grant_cnt <= cpu_grant_cnt + 16'd1;
      if (state == WAIT && sram_busy &&
          busy_stall_cnt != 16'hFFFF)
        busy_stall_cnt <= busy_stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/sram_access_arbiter.md
Name: sram_access_arbiter

Overview:
- Shares the single external SRAM port between two requesters: the VGA data controller (read-only pixel fetch) and the CPU load/store unit (read/write).
- Sequences each SRAM transaction as issue, wait-on-busy, capture, ack.
- Favours VGA during active video and guarantees bounded CPU latency with a starvation counter.
- Sits between the VGA data controller, CPU memory interface and the SRAM wrapper.

Parameters:
- ADDR_W, 32, address width of both requesters and the SRAM port
- DATA_W, 32, data word width
- CPU_STARVE_LIMIT, 16, waiting cycles after which a pending CPU request beats VGA

Ports:
- clk  in  1  system clock (25 MHz pixel clock domain)
- rst  in  1  reset, synchronous, active-high
- VGA_state  in  2  VGA timing state; 2 = active video
- vga_req  in  1  VGA read request, held until vga_ack
- vga_addr  in  ADDR_W  VGA word address
- vga_rdata  out  DATA_W  read data to VGA, valid with vga_ack, held until the next VGA ack
- vga_ack  out  1  one-cycle completion pulse
- cpu_req  in  1  CPU request, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  write data
- cpu_byte_sel  in  4  byte enables
- cpu_rdata  out  DATA_W  read data, valid with cpu_ack, held until the next CPU ack
- cpu_ack  out  1  one-cycle completion pulse
- sram_busy  in  1  SRAM busy, high while an access is in flight
- sram_rdata  in  DATA_W  SRAM read data
- sram_read  out  1  one-cycle read strobe
- sram_write  out  1  one-cycle write strobe
- sram_addr  out  ADDR_W  registered address
- sram_wdata  out  DATA_W  registered write data
- sram_byte_sel  out  4  registered byte enables; 4'b1111 for VGA

Behaviour:
- Reset (rst high at a posedge): state IDLE, every output 0, starve_cnt 0, last_grant = CPU. Reset mid-transaction abandons the access: no ack is issued and the requester must re-request.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE: if any request is pending, pick a winner, register sram_addr/wdata/byte_sel, then go to ISSUE. Otherwise stay.
- Winner selection, in priority order:
  - starve_cnt >= CPU_STARVE_LIMIT and cpu_req: CPU.
  - VGA_state == 2 and vga_req: VGA.
  - Both requesting: the requester that is not last_grant (round-robin).
  - Single requester: that requester.
- ISSUE: sram_read, or sram_write for a CPU write, high for exactly this cycle; then go to WAIT.
- WAIT: stay while sram_busy. On the first cycle sram_busy is low, capture sram_rdata into the winner's rdata register (reads only; writes leave rdata unchanged), then go to ACK.
- ACK: the winner's ack is high this cycle only; update last_grant; go to IDLE.
- Minimum latency with sram_busy never high: request sampled at edge N, strobe during cycle N+1, ack during cycle N+3. Back-to-back transactions are spaced 4 cycles apart.
- starve_cnt increments each cycle cpu_req is high and the CPU is not the active grant. It saturates at CPU_STARVE_LIMIT and clears at cpu_ack.
- Requester inputs are sampled only in IDLE; changes during a transaction are ignored.
- Simultaneous vga_req and cpu_req on the reset-release cycle: the round-robin rule gives VGA, since last_grant = CPU.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- Defined: adds outputs vga_grant_cnt[15:0], cpu_grant_cnt[15:0] and busy_stall_cnt[15:0].
  - Grant counters increment on each ack.
  - busy_stall_cnt increments on each WAIT cycle with sram_busy high.
  - All three saturate at 16'hFFFF and clear on rst.
- Undefined: these ports and registers do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package sram_arb_pkg holds:
  - state enum arb_state_t {IDLE, ISSUE, WAIT, ACK}
  - requester enum req_id_t {REQ_VGA, REQ_CPU}
  - constant VGA_ACTIVE = 2'd2
- One natural sub-module: sram_arb_select, a combinational winner picker taking the requests, VGA_state, starve flag and last_grant, and returning req_id_t and a valid bit.

Test Plan:
- VGA-only read, vga_addr=5, memory[5]=32'h6AAA5556, sram_busy low: sram_read pulses 1 cycle after the request; vga_ack 3 cycles after the request with vga_rdata=32'h6AAA5556.
- CPU write, addr 12, wdata 32'hDEADBEEF, byte_sel 4'b0011, sram_busy held 3 cycles: sram_write single pulse; cpu_ack arrives 3 cycles later than in the busy-free case; cpu_rdata unchanged.
- VGA_state=2, vga_req held continuously, cpu_req held: CPU is granted after starve_cnt reaches 16, then VGA resumes.
- VGA_state=0, both requests held: grants alternate VGA, CPU, VGA, CPU; acks every 4 cycles.
- rst asserted during WAIT: the next edge gives IDLE, all outputs 0, no ack; request re-served after release.
- With ARB_PERF_CNT_EN: 3 VGA reads and 2 CPU reads give vga_grant_cnt=3 and cpu_grant_cnt=2; busy_stall_cnt equals the total busy-high WAIT cycles.
